// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited request issue, in-order PC queue for
// outstanding requests, instruction buffer toward decode, redirect with stale drop.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] curr_pc_out,
    output logic [31:0] pc_plus_4_out
);
    localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            CW       = $clog2(DEPTH + 1);
    localparam int            CW1      = CW + 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW:0]   CREDITS  = CW1'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   pcq_mem_q [DEPTH];
    logic [31:0]   pcq_mem_d [DEPTH];
    logic [PW-1:0] pcq_rd_q, pcq_rd_d, pcq_wr_q, pcq_wr_d;
    logic [CW-1:0] pcq_cnt_q, pcq_cnt_d;
    logic [31:0]   buf_pc_q [DEPTH];
    logic [31:0]   buf_pc_d [DEPTH];
    logic [31:0]   buf_data_q [DEPTH];
    logic [31:0]   buf_data_d [DEPTH];
    logic [PW-1:0] buf_rd_q, buf_rd_d, buf_wr_q, buf_wr_d;
    logic [CW-1:0] buf_cnt_q, buf_cnt_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;

    logic req_fire, rsp_fire, rsp_stale, buf_push, buf_pop, head_valid;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // Credits cover both in-flight requests and buffered words, so the buffer cannot overflow.
    assign imem_req_valid = !rst && !redirect_valid &&
                            (({1'b0, pcq_cnt_q} + {1'b0, buf_cnt_q}) < CREDITS);
    assign imem_addr      = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_fire       = imem_rsp_valid && (pcq_cnt_q != '0);
    assign rsp_stale      = redirect_valid || (drop_cnt_q != '0);
    assign buf_push       = rsp_fire && !rsp_stale;

    assign head_valid     = !rst && (buf_cnt_q != '0);
    assign instr_valid    = head_valid && !redirect_valid;
    assign buf_pop        = instr_valid && instr_ready;
    assign instr          = head_valid ? buf_data_q[buf_rd_q] : '0;
    assign curr_pc_out    = head_valid ? buf_pc_q[buf_rd_q] : '0;
    assign pc_plus_4_out  = head_valid ? buf_pc_q[buf_rd_q] + 32'd4 : '0;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        pcq_mem_d  = pcq_mem_q;
        pcq_rd_d   = pcq_rd_q;
        pcq_wr_d   = pcq_wr_q;
        pcq_cnt_d  = pcq_cnt_q + CW'(req_fire) - CW'(rsp_fire);
        buf_pc_d   = buf_pc_q;
        buf_data_d = buf_data_q;
        buf_rd_d   = buf_rd_q;
        buf_wr_d   = buf_wr_q;
        buf_cnt_d  = buf_cnt_q + CW'(buf_push) - CW'(buf_pop);
        drop_cnt_d = drop_cnt_q;

        if (req_fire) begin
            pcq_mem_d[pcq_wr_q] = fetch_pc_q;
            pcq_wr_d            = ptr_inc(pcq_wr_q);
            fetch_pc_d          = fetch_pc_q + 32'd4;
        end
        if (rsp_fire) begin
            pcq_rd_d = ptr_inc(pcq_rd_q);
        end
        if (buf_push) begin
            buf_pc_d[buf_wr_q]   = pcq_mem_q[pcq_rd_q];
            buf_data_d[buf_wr_q] = imem_rsp_data;
            buf_wr_d             = ptr_inc(buf_wr_q);
        end
        if (buf_pop) begin
            buf_rd_d = ptr_inc(buf_rd_q);
        end
        if (rsp_fire && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
        end
        // A response arriving in the redirect cycle is already one of the stale ones.
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
            buf_rd_d   = '0;
            buf_wr_d   = '0;
            buf_cnt_d  = '0;
            drop_cnt_d = pcq_cnt_q - CW'(rsp_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC & 32'hFFFF_FFFC;
            pcq_rd_q   <= '0;
            pcq_wr_q   <= '0;
            pcq_cnt_q  <= '0;
            buf_rd_q   <= '0;
            buf_wr_q   <= '0;
            buf_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pcq_rd_q   <= pcq_rd_d;
            pcq_wr_q   <= pcq_wr_d;
            pcq_cnt_q  <= pcq_cnt_d;
            buf_rd_q   <= buf_rd_d;
            buf_wr_q   <= buf_wr_d;
            buf_cnt_q  <= buf_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        pcq_mem_q  <= pcq_mem_d;
        buf_pc_q   <= buf_pc_d;
        buf_data_q <= buf_data_d;
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: program-order model (sequential +4, redirect
// restarts, flush of undelivered words) against an in-order random-latency memory.
module tb_fetch_unit;
    localparam logic [31:0] RPC   = 32'h0000_1000;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = '0;
    logic        instr_valid, instr_ready = 1'b0;
    logic [31:0] instr, curr_pc_out, pc_plus_4_out;

    fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .curr_pc_out(curr_pc_out), .pc_plus_4_out(pc_plus_4_out)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
    typedef struct { logic [31:0] addr; int rdy; } pend_t;

    exp_t        exp_q[$];
    pend_t       pend_q[$];
    int          n_checks = 0, n_pass = 0, cyc = 0, acc_cnt = 0, deliv_cnt = 0;
    logic [31:0] exp_fetch_pc = RPC, last_pc = '0, last_p4 = '0;
    int          p_req_ready = 100, p_rsp = 100, max_extra = 0, p_instr_ready = 100, p_redirect = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %08h, expected %08h (cycle %0d)", name, act, want, cyc);
    endtask

    // Drives one cycle of inputs at posedge+1; the memory answers the oldest pending request.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        imem_req_ready = ($urandom_range(99) < p_req_ready);
        instr_ready    = ($urandom_range(99) < p_instr_ready);
        redirect_valid = !rst && ($urandom_range(999) < p_redirect);
        redirect_pc    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
        if (pend_q.size() > 0 && pend_q[0].rdy <= cyc && $urandom_range(99) < p_rsp) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_q[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
    endtask

    task automatic wait_deliv(input string name, input int d0);
        int n = 0;
        while (deliv_cnt == d0 && n < 30) begin
            step();
            n++;
        end
        if (deliv_cnt == d0) begin
            n_checks++;
            $display("FAIL %s: got no delivery in 30 cycles, expected one", name);
        end
    endtask

    // Stimulus side of the model: request order, flushes, memory pending list.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_req_valid", 32'(imem_req_valid), 0);
            chk("rst_instr_valid", 32'(instr_valid), 0);
            chk("rst_instr", instr, 0);
            chk("rst_pc", curr_pc_out, 0);
            chk("rst_pc4", pc_plus_4_out, 0);
            pend_q.delete();
            exp_q.delete();
            exp_fetch_pc = RPC;
        end else begin
            if (imem_rsp_valid && pend_q.size() > 0) void'(pend_q.pop_front());
            if (redirect_valid) begin
                chk("redir_req_valid", 32'(imem_req_valid), 0);
                chk("redir_instr_valid", 32'(instr_valid), 0);
                exp_q.delete();
                exp_fetch_pc = redirect_pc & 32'hFFFF_FFFC;
            end else if (imem_req_valid && imem_req_ready) begin
                chk("req_addr", imem_addr, exp_fetch_pc);
                exp_q.push_back('{exp_fetch_pc, mem_word(exp_fetch_pc)});
                pend_q.push_back('{imem_addr, cyc + 1 + int'($urandom_range(max_extra))});
                exp_fetch_pc += 32'd4;
                acc_cnt++;
            end
        end
    end

    // Monitor: compares every decode handshake against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && instr_valid && instr_ready) begin
            deliv_cnt++;
            last_pc = curr_pc_out;
            last_p4 = pc_plus_4_out;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_unexpected: got pc %08h, expected no delivery (cycle %0d)", curr_pc_out, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", curr_pc_out, e.pc);
                chk("sb_instr", instr, e.data);
                chk("sb_pc4", pc_plus_4_out, e.pc + 32'd4);
            end
        end else if (!rst && !redirect_valid && !instr_valid) begin
            chk("empty_instr", instr, 0);
            chk("empty_pc", curr_pc_out, 0);
            chk("empty_pc4", pc_plus_4_out, 0);
        end
    end

    initial begin
        int d0, a0, n;
        logic [31:0] a_hold;

        // Reset for two cycles, then streaming at full rate.
        step(); rst = 1'b1;
        step(); rst = 1'b1;
        step(); rst = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("first_req_valid", 32'(imem_req_valid), 1);
        chk("first_req_addr", imem_addr, 32'h0000_1000);
        step();
        @(negedge clk);
        chk("second_req_valid", 32'(imem_req_valid), 1);
        chk("second_req_addr", imem_addr, 32'h0000_1004);
        repeat (4) step();
        d0 = deliv_cnt;
        repeat (10) step();
        chk("stream_rate", 32'(deliv_cnt - d0), 10);

        // Decode stalled: exactly DEPTH requests, then release with no gaps.
        p_instr_ready = 0;
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        a0 = acc_cnt;
        repeat (11) step();
        chk("credit_accepts", 32'(acc_cnt - a0), 4);
        @(negedge clk);
        chk("credit_stall_valid", 32'(imem_req_valid), 0);
        p_instr_ready = 100;
        step();
        d0 = deliv_cnt;
        repeat (8) step();
        chk("release_rate", 32'(deliv_cnt - d0), 8);

        // Redirect with two requests outstanding.
        p_rsp = 0;
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        d0 = deliv_cnt;
        step();
        step(); redirect_valid = 1'b1; redirect_pc = 32'h0000_2002;
        p_rsp = 100;
        step();
        @(negedge clk);
        chk("redir_next_valid", 32'(imem_req_valid), 1);
        chk("redir_next_addr", imem_addr, 32'h0000_2000);
        wait_deliv("redir_wait", d0);
        chk("redir_first_pc", last_pc, 32'h0000_2000);

        // Redirect to the top of the address space: fetch wraps to zero.
        repeat (3) step();
        step(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        @(negedge clk);
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        step();
        @(negedge clk);
        chk("wrap_addr1", imem_addr, 32'h0000_0000);
        d0 = deliv_cnt;
        wait_deliv("wrap_wait", d0);
        chk("wrap_head_pc", last_pc, 32'hFFFF_FFFC);
        chk("wrap_head_pc4", last_p4, 32'h0000_0000);

        // Memory not ready for three cycles: address and valid hold.
        p_req_ready = 0;
        step();
        a_hold = exp_fetch_pc;
        repeat (3) begin
            @(negedge clk);
            chk("hold_valid", 32'(imem_req_valid), 1);
            chk("hold_addr", imem_addr, a_hold);
            step();
        end
        p_req_ready = 100;
        imem_req_ready = 1'b1;
        @(negedge clk);
        chk("hold_accept_addr", imem_addr, a_hold);
        step();
        @(negedge clk);
        chk("hold_next_addr", imem_addr, a_hold + 32'd4);

        // Random traffic with redirects, latency and one mid-run reset.
        p_req_ready = 70; p_rsp = 60; max_extra = 3; p_instr_ready = 60; p_redirect = 30;
        for (int i = 0; i < 4000; i++) begin
            step();
            rst = (i == 2000 || i == 2001);
            if (rst) redirect_valid = 1'b0;
        end

        // Drain everything still owed to decode.
        p_redirect = 0; p_req_ready = 0; p_rsp = 100; p_instr_ready = 100;
        n = 0;
        while ((exp_q.size() > 0 || pend_q.size() > 0) && n < 200) begin
            step();
            n++;
        end
        chk("drain_sb_empty", 32'(exp_q.size()), 0);
        @(negedge clk);
        chk("drain_instr_valid", 32'(instr_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test by time limit, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset (bits [1:0] treated as 0).
REQ-002 SHALL have parameter DEPTH, default 4, instruction buffer entries and maximum outstanding memory requests.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 imem_req_valid  output  1  fetch request valid.
REQ-007 imem_req_ready  input  1  memory accepts request this cycle.
REQ-008 imem_addr  output  32  word-aligned fetch address.
REQ-009 imem_rsp_valid  input  1  response valid; responses return in request order, one per accepted request, at least 1 cycle after acceptance.
REQ-010 imem_rsp_data  input  32  fetched instruction word.
REQ-011 redirect_valid  input  1  branch/jump redirect, single-cycle pulse.
REQ-012 redirect_pc  input  32  redirect target.
REQ-013 instr_valid  output  1  buffer head valid toward decode.
REQ-014 instr_ready  input  1  decode consumes head this cycle.
REQ-015 instr  output  32  head instruction word.
REQ-016 curr_pc_out  output  32  address of head instruction.
REQ-017 pc_plus_4_out  output  32  curr_pc_out + 4, modulo 2^32.

Function
REQ-018 SHALL hold fetch_pc register; imem_addr = {fetch_pc[31:2], 2'b00}.
REQ-019 SHALL assert imem_req_valid when not in reset, redirect_valid low, and outstanding + buffer_count < DEPTH (registered values).
REQ-020 SHALL advance fetch_pc by 4 (wrap 32'hFFFF_FFFC -> 0) only on imem_req_valid && imem_req_ready.
REQ-021 SHALL hold imem_addr stable while imem_req_valid is high and imem_req_ready low.
REQ-022 SHALL record the address of each accepted request in an in-order DEPTH-entry PC queue; outstanding = queue occupancy.
REQ-023 SHALL write each non-dropped response into the buffer tail as {PC-queue head, imem_rsp_data}, popping the PC queue in the same cycle.
REQ-024 SHALL present buffer head on instr/curr_pc_out/pc_plus_4_out; when buffer empty, instr_valid = 0 and instr, curr_pc_out, pc_plus_4_out = 0.
REQ-025 SHALL pop the head on instr_valid && instr_ready; a response written this cycle becomes visible no earlier than the next cycle.
REQ-026 SHALL support simultaneous push and pop in one cycle with count unchanged; the credit rule (REQ-019) guarantees the buffer never overflows.
REQ-027 SHALL, on redirect_valid: set fetch_pc = {redirect_pc[31:2], 2'b00}, empty the buffer, set drop_count = outstanding, issue no request that cycle.
REQ-028 SHALL force instr_valid = 0 in a cycle with redirect_valid high; no handshake to decode occurs that cycle.
REQ-029 SHALL discard responses while drop_count > 0, decrementing drop_count and popping the PC queue; a response in the redirect cycle itself counts as stale.
REQ-030 SHALL ignore imem_rsp_valid when outstanding = 0.
REQ-031 SHALL sustain one instruction per cycle with a latency-1 memory, imem_req_ready = 1, and instr_ready = 1.
REQ-032 SHALL deliver instructions in fetch order with no loss or duplication under any backpressure.

Reset
REQ-033 SHALL, while rst is high: fetch_pc = RESET_PC, buffer, PC queue and drop_count cleared, imem_req_valid = 0, instr_valid = 0, data outputs 0.
REQ-034 SHALL abandon in-flight requests when rst is asserted mid-operation; responses arriving after reset with outstanding = 0 are ignored (REQ-030).
REQ-035 SHALL issue the first request in the first cycle after rst deasserts.

Verification
REQ-036 RESET_PC=0x1000, rst high 2 cycles, latency-1 memory -> requests 0x1000, 0x1004 on consecutive cycles; instr_valid 0 throughout reset.
REQ-037 Streaming, instr_ready=1 -> curr_pc_out 0x1000, 0x1004, 0x1008 on consecutive cycles with matching instr; pc_plus_4_out = pc+4.
REQ-038 instr_ready=0 -> imem_req_valid drops after 4 buffered; raising instr_ready then yields all in order with no gaps or repeats.
REQ-039 Redirect to 0x2002 with 2 outstanding -> next imem_addr 0x2000; both stale responses dropped; next delivered curr_pc_out 0x2000.
REQ-040 Redirect to 0xFFFF_FFFC -> requests 0xFFFF_FFFC then 0x0000_0000; head shows pc_plus_4_out 0x0000_0000.
REQ-041 imem_req_ready low 3 cycles -> imem_addr and imem_req_valid held constant; fetch_pc advances only on acceptance.
